// File: rtl/spi_loader_pkg.sv
// Shared constants and state encoding for the SPI memory-loader master.
package spi_loader_pkg;
  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam int         FRAME_BITS = 72;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
endpackage

// File: rtl/spi_mem_loader_master_if.sv
// Host-side request/response bundle of the SPI memory-loader master.
interface spi_mem_loader_master_if #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
);
  logic                      start;
  logic                      cmd_wr;
  logic [ADDRESS_LENGTH-1:0] addr;
  logic [DATA_LENGTH-1:0]    wdata;
  logic                      busy;
  logic                      done;
  logic [DATA_LENGTH-1:0]    rdata;
  logic                      verify_err;

  modport master (output start, cmd_wr, addr, wdata,
                  input  busy, done, rdata, verify_err);
  modport slave  (input  start, cmd_wr, addr, wdata,
                  output busy, done, rdata, verify_err);
endinterface

// File: rtl/spi_sclk_gen.sv
// Divider for the SPI master: one phase_end strobe every CLK_DIV enabled cycles,
// qualified into rise/fall strobes while the master is shifting.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic shifting,
  input  logic sclk_hi,
  output logic rise_stb,
  output logic fall_stb,
  output logic phase_end
);
  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign phase_end = en && (div_q == DIV_LAST);
  assign rise_stb  = phase_end && shifting && !sclk_hi;
  assign fall_stb  = phase_end && shifting && sclk_hi;

  always_comb begin
    div_d = div_q + 1'b1;
    if (!en || phase_end) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end
endmodule

// File: rtl/spi_mem_loader_master.sv
// SPI mode-0 master issuing 72-bit opcode/address/data frames to the memory loader.
// Define SPI_LOADER_VERIFY_EN to follow every write with an automatic readback check.
module spi_mem_loader_master
  import spi_loader_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_mem_loader_master_if.slave  bus,
  output logic                    ss,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso
);
  localparam logic [6:0] BIT_LAST = 7'(FRAME_BITS - 1);
  localparam logic [6:0] DATA_TOP = 7'(DATA_LENGTH);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d, req_frame, rb_frame;
  logic [6:0]              bit_cnt_q, bit_cnt_d;
  logic                    ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                    busy_q, busy_d, done_q, done_d, is_wr_q, is_wr_d;
  logic [DATA_LENGTH-1:0]  cap_q, cap_d, rdata_q, rdata_d;
  logic                    rise_stb, fall_stb, phase_end, accept, frame_end, chain_rd;

  assign req_frame = {bus.cmd_wr ? OP_WRITE : OP_READ, bus.addr,
                      bus.cmd_wr ? bus.wdata : {DATA_LENGTH{1'b0}}};
  assign accept    = (state_q == IDLE) && bus.start;
  assign frame_end = (state_q == GAP) && phase_end;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q != IDLE),
    .shifting  (state_q == SHIFT),
    .sclk_hi   (sclk_q),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .phase_end (phase_end)
  );

`ifdef SPI_LOADER_VERIFY_EN
  logic [ADDRESS_LENGTH-1:0] vaddr_q, vaddr_d;
  logic [DATA_LENGTH-1:0]    vwdata_q, vwdata_d;
  logic                      pend_q, pend_d, check_q, check_d, verr_q, verr_d;

  // A write leaves pend set so its GAP chains into a readback; check marks that readback.
  always_comb begin
    vaddr_d  = vaddr_q;
    vwdata_d = vwdata_q;
    pend_d   = pend_q;
    check_d  = check_q;
    verr_d   = verr_q;
    if (accept) begin
      vaddr_d  = bus.addr;
      vwdata_d = bus.wdata;
      pend_d   = bus.cmd_wr;
      check_d  = 1'b0;
      verr_d   = 1'b0;
    end else if (frame_end) begin
      if (pend_q) begin
        pend_d  = 1'b0;
        check_d = 1'b1;
      end else if (check_q) begin
        check_d = 1'b0;
        verr_d  = (cap_q != vwdata_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr_q  <= '0;
      vwdata_q <= '0;
      pend_q   <= 1'b0;
      check_q  <= 1'b0;
      verr_q   <= 1'b0;
    end else begin
      vaddr_q  <= vaddr_d;
      vwdata_q <= vwdata_d;
      pend_q   <= pend_d;
      check_q  <= check_d;
      verr_q   <= verr_d;
    end
  end

  assign chain_rd       = pend_q;
  assign rb_frame       = {OP_READ, vaddr_q, {DATA_LENGTH{1'b0}}};
  assign bus.verify_err = verr_q;
`else
  assign chain_rd       = 1'b0;
  assign rb_frame       = '0;
  assign bus.verify_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    is_wr_d   = is_wr_q;
    cap_d     = cap_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d   = SETUP;
        shreg_d   = req_frame;
        mosi_d    = req_frame[FRAME_BITS-1];
        ss_d      = 1'b0;
        busy_d    = 1'b1;
        bit_cnt_d = BIT_LAST;
        is_wr_d   = bus.cmd_wr;
      end
      SETUP: if (phase_end) state_d = SHIFT;
      // Only the trailing data bits are captured; opcode/address-phase miso is ignored.
      SHIFT: begin
        if (rise_stb) begin
          sclk_d = 1'b1;
          if (bit_cnt_q < DATA_TOP) cap_d = {cap_q[DATA_LENGTH-2:0], miso};
        end else if (fall_stb) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = HOLD;
          end else begin
            shreg_d   = shreg_q << 1;
            mosi_d    = shreg_q[FRAME_BITS-2];
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      HOLD: if (phase_end) begin
        state_d = GAP;
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
      end
      GAP: if (frame_end) begin
        if (chain_rd) begin
          state_d   = SETUP;
          shreg_d   = rb_frame;
          mosi_d    = rb_frame[FRAME_BITS-1];
          ss_d      = 1'b0;
          bit_cnt_d = BIT_LAST;
          is_wr_d   = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!is_wr_q) rdata_d = cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_wr_q   <= 1'b0;
      cap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_wr_q   <= is_wr_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ss        = ss_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: doc/spi_mem_loader_master.md
Name: spi_mem_loader_master

Overview:
SPI master (mode 0, MSB first) that drives the ss/sclk/mosi/miso port of the core's SPI memory-loader interface from the host/test side.
- Issues one 72-bit frame per request: 8-bit opcode, 32-bit address, 32-bit data.
- Write frames load program/data words into the shared data memory while the interface owns it (core_select low).
- Read frames return a memory word captured from miso.

Parameters:
- CLK_DIV, 2, sclk half-period in clk cycles; legal range ≥1.
- ADDRESS_LENGTH, 32, address field width.
- DATA_LENGTH, 32, data field width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request strobe; sampled only when busy=0.
- cmd_wr  input  1  1 = write frame, 0 = read frame.
- addr  input  ADDRESS_LENGTH  target word address.
- wdata  input  DATA_LENGTH  write data; ignored for reads.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at frame completion.
- rdata  output  DATA_LENGTH  read result.
- verify_err  output  1  readback mismatch flag; see Optional Feature.
- ss  output  1  slave select, active low.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, verify_err=0, bit counter=0, divider=0. A partial frame is abandoned; the slave discards it when ss rises.
- Frame format, bits 71..0 sent MSB first:
  - Opcode: 8'h01 write, 8'h02 read.
  - Address: addr[31:0].
  - Data: wdata for writes, 32'h0 for reads.
- Accept: start=1 while in IDLE latches cmd_wr/addr/wdata into a 72-bit shift register. start while busy is ignored and not queued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - SETUP: ss=0, mosi=bit71, sclk low for CLK_DIV cycles.
  - SHIFT: per bit, sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - miso is sampled in the clk cycle in which sclk rises.
    - On each sclk fall, the shift register shifts left and mosi updates to the next bit.
    - After bit 0's high phase, sclk returns low and the state moves to HOLD. There is no extra shift.
  - HOLD: ss=0, sclk=0 for CLK_DIV cycles.
  - GAP: ss=1 for CLK_DIV cycles. On the last GAP cycle, done=1 and busy=0 are registered together; the state returns to IDLE.
- Latency: start sampled at edge 0 -> done high after edge 147*CLK_DIV (CLK_DIV + 144*CLK_DIV + CLK_DIV + CLK_DIV). CLK_DIV=2 gives 294.
- Read capture:
  - The 32 miso samples from bits 31..0 shift into a capture register.
  - rdata updates in the same cycle done asserts, on read frames only. Write frames leave rdata unchanged.
  - miso during opcode/address bits is ignored.
- A new start is accepted in the cycle done is high, because the state is already IDLE. This gives back-to-back frames with ss high for CLK_DIV cycles.
- Bit counter is 7 bits, counts 71 down to 0, and never wraps within a frame. Divider is ceil(log2(CLK_DIV+1)) bits.

Optional Feature:
- Macro: SPI_LOADER_VERIFY_EN.
- Defined:
  - After a write frame completes GAP, the block automatically issues a read frame to the same address, keeping busy high. The write frame does not pulse done.
  - At the read's completion, done pulses and rdata updates.
  - verify_err is set to (rdata != wdata). It holds until the next accepted start or reset.
  - Write latency doubles to 294*CLK_DIV.
- Undefined: verify_err is tied to 0; writes complete after a single frame.

Decomposition:
- Package spi_loader_pkg holds:
  - OP_WRITE=8'h01, OP_READ=8'h02, FRAME_BITS=72.
  - State enum {IDLE, SETUP, SHIFT, HOLD, GAP}.
- One sub-module, spi_sclk_gen: divider counter plus one-cycle rise_stb/fall_stb/phase_end strobes, enabled by the FSM.
- Shift register, capture register and FSM stay in spi_mem_loader_master.

Test Plan:
- Reset values: rst_n low -> ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0.
- Write frame: CLK_DIV=2, write addr=32'h0000_0010, wdata=32'hDEAD_BEEF -> mosi bits on rising sclk decode to 8'h01, 32'h10, 32'hDEADBEEF. Exactly 72 sclk rises; done pulses at cycle 294.
- Read frame: read addr=32'h4 with a slave model driving 32'h1234_5678 during data bits -> rdata=32'h12345678 at done. A miso toggle during the address phase does not affect rdata.
- Back-to-back: start held high across done -> second frame begins with ss high for exactly CLK_DIV cycles; start during busy is ignored.
- Async reset: rst_n pulsed low at bit 40 -> ss=1 and sclk=0 immediately with no clk edge. A following write completes normally.
- SPI_LOADER_VERIFY_EN: slave model corrupts readback to 32'hDEAD_BEEE -> one done pulse at cycle 588 and verify_err=1. Matching data gives verify_err=0.
